// File: rtl/mdu.sv
// Multiply/divide unit for the E stage: owns HI/LO, runs mult/multu/div/divu
// over a fixed number of busy cycles and serves mfhi/mflo reads.
module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_D,
  input  logic [31:0] IR_E,
  input  logic [31:0] RS_E,
  input  logic [31:0] RT_E,
  input  logic        exc_flush,
  output logic        start,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] md_rdata
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [5:0] FN_MFHI = 6'b010000;
  localparam logic [5:0] FN_MTHI = 6'b010001;
  localparam logic [5:0] FN_MFLO = 6'b010010;
  localparam logic [5:0] FN_MTLO = 6'b010011;

  logic [CNT_W-1:0] count;
  logic [31:0]      op_a;
  logic [31:0]      op_b;
  logic [1:0]       op_kind;   // func[1:0]: 00 mult, 01 multu, 10 div, 11 divu

  // Instruction decode for the E and D stages
  logic e_special, d_special;
  logic e_muldiv, e_mthi, e_mtlo, e_mfhi, e_mflo, d_md_class;

  assign e_special  = (IR_E[31:26] == 6'b000000);
  assign d_special  = (IR_D[31:26] == 6'b000000);
  assign e_muldiv   = e_special && (IR_E[5:2] == 4'b0110);
  assign e_mthi     = e_special && (IR_E[5:0] == FN_MTHI);
  assign e_mtlo     = e_special && (IR_E[5:0] == FN_MTLO);
  assign e_mfhi     = e_special && (IR_E[5:0] == FN_MFHI);
  assign e_mflo     = e_special && (IR_E[5:0] == FN_MFLO);
  assign d_md_class = d_special && ((IR_D[5:2] == 4'b0110) || (IR_D[5:2] == 4'b0100));

  logic unused_ir_bits;
  assign unused_ir_bits = ^{IR_D[25:6], IR_D[1:0], IR_E[25:6]};

  assign start    = e_muldiv && !busy && !exc_flush;
  assign stall_md = d_md_class && (start || busy);

  always_comb begin
    md_rdata = 32'd0;
    if (e_mfhi)      md_rdata = HI;
    else if (e_mflo) md_rdata = LO;
  end

  // Multiply: operands extended to 64 bits according to signedness
  logic        is_signed;
  logic [63:0] a_ext, b_ext, product;

  assign is_signed = !op_kind[0];
  assign a_ext     = {{32{is_signed & op_a[31]}}, op_a};
  assign b_ext     = {{32{is_signed & op_b[31]}}, op_b};
  assign product   = a_ext * b_ext;

  // Divide on magnitudes, then restore signs; also covers 0x80000000 / -1
  logic        a_neg, b_neg, div_by_zero;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quotient, remainder;

  assign a_neg       = is_signed & op_a[31];
  assign b_neg       = is_signed & op_b[31];
  assign a_mag       = a_neg ? (32'd0 - op_a) : op_a;
  assign b_mag       = b_neg ? (32'd0 - op_b) : op_b;
  assign div_by_zero = (op_b == 32'd0);
  assign b_safe      = div_by_zero ? 32'd1 : b_mag;
  assign q_mag       = a_mag / b_safe;
  assign r_mag       = a_mag % b_safe;
  assign quotient    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign remainder   = a_neg ? (32'd0 - r_mag) : r_mag;

  always_ff @(posedge clk) begin
    if (reset) begin
      HI      <= 32'd0;
      LO      <= 32'd0;
      busy    <= 1'b0;
      count   <= '0;
      op_a    <= 32'd0;
      op_b    <= 32'd0;
      op_kind <= 2'b00;
    end else if (busy) begin
      count <= count - CNT_W'(1);
      if (count == CNT_W'(1)) begin
        busy <= 1'b0;
        if (!op_kind[1]) begin
          HI <= product[63:32];
          LO <= product[31:0];
        end else if (!div_by_zero) begin
          HI <= remainder;
          LO <= quotient;
        end
      end
    end else if (start) begin
      op_a    <= RS_E;
      op_b    <= RT_E;
      op_kind <= IR_E[1:0];
      count   <= IR_E[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
      busy    <= 1'b1;
    end else if (!exc_flush) begin
      if (e_mthi) HI <= RS_E;
      if (e_mtlo) LO <= RS_E;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: table of mult/div vectors through a scoreboard,
// plus hand sequences for stall, divide-by-zero, flush and reset corners.
module tb_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IR_D, IR_E, RS_E, RT_E;
  logic        exc_flush;
  logic        start, busy, stall_md;
  logic [31:0] HI, LO, md_rdata;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  typedef struct {
    string       name;
    logic [5:0]  func;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } vec_t;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  vec_t vecs[10];
  exp_t sb[$];

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .IR_D(IR_D), .IR_E(IR_E), .RS_E(RS_E), .RT_E(RT_E),
    .exc_flush(exc_flush), .start(start), .busy(busy), .stall_md(stall_md),
    .HI(HI), .LO(LO), .md_rdata(md_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ir(input logic [5:0] fn);
    return {26'd0, fn};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Entered just after an edge with busy expected high; counts busy cycles
  // and returns at the negedge of the first idle cycle.
  task automatic wait_done(input string name, output int n);
    bit done;
    done = 1'b0;
    n = 0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (busy) begin
        n++;
        cyc();
      end else begin
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: busy still high after 64 cycles", name);
    end
  endtask

  // Called just after an edge; launches the op in this cycle (T).
  task automatic run_op(input vec_t v);
    int   n;
    exp_t e;
    IR_E = ir(v.func);
    RS_E = v.rs;
    RT_E = v.rt;
    @(negedge clk);
    chk({v.name, " start"}, 32'(start), 32'd1);
    sb.push_back('{hi: v.hi, lo: v.lo});
    cyc();
    IR_E = 32'd0;
    RS_E = 32'd0;
    RT_E = 32'd0;
    wait_done(v.name, n);
    chk({v.name, " busy_cycles"}, 32'(n), 32'(v.cycles));
    e = sb.pop_front();
    chk({v.name, " HI"}, HI, e.hi);
    chk({v.name, " LO"}, LO, e.lo);
    cyc();
  endtask

  initial begin
    int n;

    vecs[0] = '{"mult_neg1x2",   F_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 5};
    vecs[1] = '{"multu_big_x2",  F_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2] = '{"div_m7_2",      F_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{"divu_7_2",      F_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 10};
    vecs[4] = '{"div_min_m1",    F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[5] = '{"mult_min_min",  F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
    vecs[6] = '{"divu_max_16",   F_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 10};
    vecs[7] = '{"div_7_m2",      F_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[8] = '{"multu_max_max", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[9] = '{"mult_7_m3",     F_MULT,  32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 5};

    reset = 1'b1;
    IR_D = 32'd0; IR_E = 32'd0; RS_E = 32'd0; RT_E = 32'd0; exc_flush = 1'b0;
    repeat (2) cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset HI", HI, 32'd0);
    chk("reset LO", LO, 32'd0);
    chk("reset start", 32'(start), 32'd0);
    cyc();

    foreach (vecs[i]) run_op(vecs[i]);

    // Preload HI/LO, then divide by zero with mflo waiting in D
    IR_E = ir(F_MTHI); RS_E = 32'h11111111;
    cyc();
    IR_E = ir(F_MTLO); RS_E = 32'h22222222;
    cyc();
    IR_E = ir(F_DIV); RS_E = 32'h00000005; RT_E = 32'd0; IR_D = ir(F_MFLO);
    @(negedge clk);
    chk("dz start", 32'(start), 32'd1);
    chk("dz stall T", 32'(stall_md), 32'd1);
    for (int i = 1; i <= 10; i++) begin
      cyc();
      IR_E = 32'd0; RS_E = 32'd0; RT_E = 32'd0;
      @(negedge clk);
      chk($sformatf("dz stall T+%0d", i), 32'(stall_md), 32'd1);
    end
    cyc();
    @(negedge clk);
    chk("dz busy T+11", 32'(busy), 32'd0);
    chk("dz stall T+11", 32'(stall_md), 32'd0);
    chk("dz HI", HI, 32'h11111111);
    chk("dz LO", LO, 32'h22222222);
    chk("nop md_rdata", md_rdata, 32'd0);
    cyc();
    IR_E = ir(F_MFLO); IR_D = ir(F_MFHI);
    @(negedge clk);
    chk("mflo md_rdata", md_rdata, 32'h22222222);
    cyc();
    IR_E = ir(F_MFHI); IR_D = 32'd0;
    @(negedge clk);
    chk("mfhi md_rdata", md_rdata, 32'h11111111);
    cyc();

    // Flushed mult and mthi must not touch state
    IR_E = ir(F_MULT); RS_E = 32'd3; RT_E = 32'd3; exc_flush = 1'b1;
    @(negedge clk);
    chk("flush start", 32'(start), 32'd0);
    cyc();
    IR_E = 32'd0; exc_flush = 1'b0;
    @(negedge clk);
    chk("flush busy", 32'(busy), 32'd0);
    chk("flush HI", HI, 32'h11111111);
    chk("flush LO", LO, 32'h22222222);
    cyc();
    IR_E = ir(F_MTHI); RS_E = 32'hDEADBEEF; exc_flush = 1'b1;
    cyc();
    IR_E = 32'd0; exc_flush = 1'b0;
    @(negedge clk);
    chk("flush mthi HI", HI, 32'h11111111);
    cyc();
    IR_E = ir(F_MTHI); RS_E = 32'hDEADBEEF;
    cyc();
    IR_E = 32'd0; RS_E = 32'd0;
    @(negedge clk);
    chk("mthi HI", HI, 32'hDEADBEEF);
    cyc();

    // No launch while busy; a flush after launch does not cancel the op
    IR_E = ir(F_MULT); RS_E = 32'd6; RT_E = 32'd7;
    cyc();
    IR_E = ir(F_MULT); RS_E = 32'd9; RT_E = 32'd9;
    @(negedge clk);
    chk("busy blocks start", 32'(start), 32'd0);
    cyc();
    IR_E = 32'd0; exc_flush = 1'b1;
    cyc();
    exc_flush = 1'b0;
    wait_done("inflight_flush", n);
    chk("inflight_flush remaining", 32'(n), 32'd3);
    chk("inflight_flush HI", HI, 32'd0);
    chk("inflight_flush LO", LO, 32'd42);
    cyc();

    // Reset mid-divide aborts the operation
    IR_E = ir(F_DIVU); RS_E = 32'd100; RT_E = 32'd7;
    cyc();
    IR_E = 32'd0; RS_E = 32'd0; RT_E = 32'd0;
    repeat (3) cyc();
    reset = 1'b1;
    @(negedge clk);
    chk("pre-reset busy", 32'(busy), 32'd1);
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("rst mid busy", 32'(busy), 32'd0);
    chk("rst mid HI", HI, 32'd0);
    chk("rst mid LO", LO, 32'd0);
    repeat (12) cyc();
    @(negedge clk);
    chk("rst late HI", HI, 32'd0);
    chk("rst late LO", LO, 32'd0);
    cyc();
    run_op('{"mult_after_rst", F_MULT, 32'd3, 32'd5, 32'd0, 32'd15, 5});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
